// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard unit.
// The operand muxes decode fwd_*_sel with the same FWD_* constants.
package fwd_hazard_unit_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    // Full slot for the instruction currently in EX.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dst;
        logic              reg_write;
        logic              mem_read;
    } ex_slot_t;

    // MEM and WB only need to know what they will write.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              reg_write;
    } late_slot_t;

    // A slot is a forwarding source only if it really writes a non-zero register.
    function automatic logic writes_reg(input late_slot_t s);
        return s.valid && s.reg_write && (s.dst != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and EX-operand-select bundle between the core and the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int REG_AW = fwd_hazard_unit_pkg::REG_AW
) ();

    // id_valid qualifies every id_* field for the current cycle. There is no ready:
    // while stall_id is high the core re-presents the same ID instruction next cycle.
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rt_used;
    logic [REG_AW-1:0] id_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              ex_flush;

    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall_id;

    modport master (
        output id_valid, id_rs, id_rt, id_rt_used, id_dst, id_reg_write, id_mem_read,
        output ex_flush,
        input  fwd_a_sel, fwd_b_sel, stall_id
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rt_used, id_dst, id_reg_write, id_mem_read,
        input  ex_flush,
        output fwd_a_sel, fwd_b_sel, stall_id
    );

endinterface

// File: rtl/fwd_hazard_unit_fwd_match.sv
// Per-operand forwarding comparator: picks EX/MEM over WB over the register file.
module fwd_match
    import fwd_hazard_unit_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src,
    input  late_slot_t    mem,
    input  late_slot_t    wb,
    output logic [1:0]    sel
);

    always_comb begin
        sel = FWD_RF;
        if (writes_reg(mem) && (mem.dst == src)) begin
            sel = FWD_MEM;
        end else if (writes_reg(wb) && (wb.dst == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects and one-cycle load-use stall for the 5-stage core.
// Optional stall counter port/logic built only when FWD_PERF_CNT_EN is defined.
module fwd_hazard_unit #(
    parameter int REG_AW = 5
`ifdef FWD_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    fwd_hazard_unit_if.slave      bus
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    import fwd_hazard_unit_pkg::*;

    ex_slot_t   ex_q;
    ex_slot_t   ex_d;
    late_slot_t mem_q;
    late_slot_t wb_q;

    logic       stall;
    logic       ex_is_load;
    logic       hit_rs;
    logic       hit_rt;

    // Only a real load in EX writing a non-zero register can cause a load-use stall.
    assign ex_is_load = ex_q.valid && ex_q.mem_read && (ex_q.dst != '0);
    assign hit_rs     = (ex_q.dst == bus.id_rs);
    assign hit_rt     = bus.id_rt_used && (ex_q.dst == bus.id_rt);
    assign stall      = bus.id_valid && ex_is_load && (hit_rs || hit_rt);

    assign bus.stall_id = stall;

    // Stall, flush and an empty ID all hand EX a bubble; flush wins over the ID hold.
    always_comb begin
        ex_d = '0;
        if (bus.id_valid && !stall && !bus.ex_flush) begin
            ex_d.valid     = 1'b1;
            ex_d.rs        = bus.id_rs;
            ex_d.rt        = bus.id_rt;
            ex_d.dst       = bus.id_dst;
            ex_d.reg_write = bus.id_reg_write;
            ex_d.mem_read  = bus.id_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= '{valid: ex_q.valid, dst: ex_q.dst, reg_write: ex_q.reg_write};
            wb_q  <= mem_q;
        end
    end

    fwd_match #(
        .AW  (REG_AW)
    ) u_match_a (
        .src (ex_q.rs),
        .mem (mem_q),
        .wb  (wb_q),
        .sel (bus.fwd_a_sel)
    );

    fwd_match #(
        .AW  (REG_AW)
    ) u_match_b (
        .src (ex_q.rt),
        .mem (mem_q),
        .wb  (wb_q),
        .sel (bus.fwd_b_sel)
    );

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

    sel_never_three: assert property (@(posedge clk) disable iff (rst)
        (bus.fwd_a_sel != 2'd3) && (bus.fwd_b_sel != 2'd3));

    // A stall always leaves a bubble in EX, so it can never repeat back-to-back.
    stall_one_cycle: assert property (@(posedge clk) disable iff (rst)
        stall |=> !stall);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: vector table plus hand-written multi-cycle sequences.
module tb_fwd_hazard_unit;

    import fwd_hazard_unit_pkg::*;

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ru;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
        logic       fl;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    vec_t       vecs[$];
    logic [4:0] exp_q[$];
    int         tests;
    int         fails;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_AW(5)) bus ();

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fwd_hazard_unit #(
        .REG_AW    (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef FWD_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    function automatic vec_t mk(input string name, input logic v, input logic [4:0] rs,
                                input logic [4:0] rt, input logic ru, input logic [4:0] dst,
                                input logic rw, input logic mr, input logic fl,
                                input logic [1:0] ea, input logic [1:0] eb, input logic es);
        vec_t t;
        t.name = name; t.v = v; t.rs = rs; t.rt = rt; t.ru = ru; t.dst = dst;
        t.rw = rw; t.mr = mr; t.fl = fl; t.ea = ea; t.eb = eb; t.es = es;
        return t;
    endfunction

    function automatic vec_t idle(input string name);
        return mk(name, 0, 0, 0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, 0);
    endfunction

    task automatic drive_id(input vec_t t);
        bus.id_valid     = t.v;
        bus.id_rs        = t.rs;
        bus.id_rt        = t.rt;
        bus.id_rt_used   = t.ru;
        bus.id_dst       = t.dst;
        bus.id_reg_write = t.rw;
        bus.id_mem_read  = t.mr;
        bus.ex_flush     = t.fl;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name);
        logic [4:0] e;
        e = exp_q.pop_front();
        check_val({name, " fwd_a_sel"}, 32'(bus.fwd_a_sel), 32'(e[4:3]));
        check_val({name, " fwd_b_sel"}, 32'(bus.fwd_b_sel), 32'(e[2:1]));
        check_val({name, " stall_id"},  32'(bus.stall_id),  32'(e[0]));
    endtask

    // Drive one cycle's ID inputs, check the outputs mid-cycle, then advance to the next negedge.
    task automatic step(input vec_t t);
        drive_id(t);
        exp_q.push_back({t.ea, t.eb, t.es});
        #1;
        check_outputs(t.name);
        @(negedge clk);
    endtask

    task automatic check_cnt(input string name, input int exp);
`ifdef FWD_PERF_CNT_EN
        check_val(name, stall_cnt, 32'(exp));
`else
        if (exp < 0) $display("%s: negative count", name);
`endif
    endtask

    initial begin
        vec_t r;
        tests = 0;
        fails = 0;

        // Reset with random ID inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r = mk("reset", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0);
            drive_id(r);
            @(negedge clk);
            exp_q.push_back(5'b0);
            #1;
            check_outputs("reset");
        end
        check_cnt("reset stall_cnt", 0);
        rst = 1'b0;

        // name, v, rs, rt, ru, dst, rw, mr, fl, exp_a, exp_b, exp_stall
        vecs.push_back(mk("exmem prod",  1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("exmem cons",  1, 3, 7, 1, 6, 1, 0, 0, 0, 0, 0));
        vecs.push_back(idle("exmem chk"));  vecs[$].ea = FWD_MEM;
        vecs.push_back(idle("exmem d1"));
        vecs.push_back(idle("exmem d2"));

        vecs.push_back(mk("wb prod",     1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("wb mid",      1, 9, 10, 1, 8, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("wb cons",     1, 11, 3, 1, 12, 1, 0, 0, 0, 0, 0));
        vecs.push_back(idle("wb chk"));     vecs[$].eb = FWD_WB;
        vecs.push_back(idle("wb d1"));
        vecs.push_back(idle("wb d2"));

        vecs.push_back(mk("pri w1",      1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("pri w2",      1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("pri rd",      1, 5, 5, 1, 13, 1, 0, 0, 0, 0, 0));
        vecs.push_back(idle("pri chk"));    vecs[$].ea = FWD_MEM; vecs[$].eb = FWD_MEM;
        vecs.push_back(idle("pri d1"));
        vecs.push_back(idle("pri d2"));

        vecs.push_back(mk("zero lw",     1, 1, 2, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("zero rd1",    1, 0, 0, 1, 14, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("zero rd2",    1, 0, 0, 1, 15, 1, 0, 0, 0, 0, 0));
        vecs.push_back(idle("zero chk"));
        vecs.push_back(idle("zero d1"));
        vecs.push_back(idle("zero d2"));

        vecs.push_back(mk("ldi lw",      1, 1, 4, 0, 4, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("ldi rt unused", 1, 2, 4, 0, 4, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("ldi lw2",     1, 1, 9, 0, 9, 1, 1, 0, 0, FWD_MEM, 0));
        vecs.push_back(mk("ldi id inv",  0, 9, 9, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(idle("ldi d1"));
        vecs.push_back(idle("ldi d2"));

        vecs.push_back(mk("flush prod",  1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("flush cons",  1, 3, 3, 1, 6, 1, 0, 1, 0, 0, 0));
        vecs.push_back(idle("flush chk"));
        vecs.push_back(idle("flush d1"));

        vecs.push_back(mk("nrw prod",    1, 1, 2, 1, 7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("nrw store",   1, 1, 2, 1, 7, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("nrw rd",      1, 7, 2, 1, 16, 1, 0, 0, 0, 0, 0));
        vecs.push_back(idle("nrw chk"));    vecs[$].ea = FWD_WB;
        vecs.push_back(idle("nrw d1"));
        vecs.push_back(idle("nrw d2"));

        foreach (vecs[i]) step(vecs[i]);

        // Load-use on rs: one stall cycle, consumer then forwards from WB
        step(mk("lu lw",    1, 1, 4, 0, 4, 1, 1, 0, 0, 0, 0));
        step(mk("lu stall", 1, 4, 2, 1, 7, 1, 0, 0, 0, 0, 1));
        step(mk("lu held",  1, 4, 2, 1, 7, 1, 0, 0, 0, 0, 0));
        step(mk("lu chk",   0, 0, 0, 0, 0, 0, 0, 0, FWD_WB, 0, 0));
        step(idle("lu d1"));
        step(idle("lu d2"));
        check_cnt("lu stall_cnt", 1);

        // Load-use on rt of a branch
        step(mk("lurt lw",    1, 1, 9, 0, 9, 1, 1, 0, 0, 0, 0));
        step(mk("lurt stall", 1, 2, 9, 1, 0, 0, 0, 0, 0, 0, 1));
        step(mk("lurt held",  1, 2, 9, 1, 0, 0, 0, 0, 0, 0, 0));
        step(mk("lurt chk",   0, 0, 0, 0, 0, 0, 0, 0, 0, FWD_WB, 0));
        step(idle("lurt d1"));
        step(idle("lurt d2"));
        check_cnt("lurt stall_cnt", 2);

        // Flush on the stall cycle: stall still raised, squashed slot never forwards
        step(mk("fs lw",     1, 1, 4, 0, 4, 1, 1, 0, 0, 0, 0));
        step(mk("fs stall",  1, 4, 2, 1, 7, 1, 0, 1, 0, 0, 1));
        step(idle("fs bubble"));
        step(idle("fs chk"));
        check_cnt("fs stall_cnt", 3);

        // Mid-operation reset forgets in-flight producers and pending loads
        step(mk("rst prod", 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0));
        rst = 1'b1;
        step(mk("rst cons", 1, 3, 3, 1, 6, 1, 0, 0, 0, 0, 0));
        rst = 1'b0;
        step(idle("rst lost fwd"));
        step(mk("rst lw",   1, 1, 4, 0, 4, 1, 1, 0, 0, 0, 0));
        rst = 1'b1;
        step(idle("rst mid"));
        rst = 1'b0;
        check_cnt("rst stall_cnt", 0);
        step(mk("rst no stall", 1, 4, 2, 1, 7, 1, 0, 0, 0, 0, 0));
        step(idle("rst d1"));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Pipelined forwarding and hazard controller for the 5-stage MIPS core. It tracks destination-register state for the instructions it has seen in ID, EX, MEM and WB. From that state it drives the 2-bit select inputs of the two EX-stage ALU operand multiplexers (register-file value, WB result, or EX/MEM ALU result), and it raises a one-cycle load-use stall. It sits beside the ID/EX pipeline register and is the producer of the selects the operand muxes consume.

## Interface
Parameters:
- REG_AW, 5, register-address width
- CNT_W, 32, stall-counter width (only with FWD_PERF_CNT_EN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  ID source register A
- id_rt  in  REG_AW  ID source register B
- id_rt_used  in  1  rt is a true source (R-type, beq, sw), not a destination
- id_dst  in  REG_AW  ID destination register (already rd/rt-selected)
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- ex_flush  in  1  branch taken; squash the instruction entering EX
- fwd_a_sel  out  2  select for ALU operand A mux: 0 = RF, 1 = WB result, 2 = EX/MEM ALU result
- fwd_b_sel  out  2  same encoding, operand B
- stall_id  out  1  hold PC and IF/ID; insert bubble into EX
- stall_cnt  out  CNT_W  cycles with stall_id=1 (only with FWD_PERF_CNT_EN)

## Operation
- Three internal stage slots: EX, MEM, WB. Each slot holds {valid, rs, rt, dst, reg_write, mem_read}. MEM and WB keep only {valid, dst, reg_write}.
- Every cycle: WB <= MEM, MEM <= EX, EX <= ID fields. Exception: the EX slot loads a bubble (all zeros) when stall_id=1, ex_flush=1 or id_valid=0.
- Operand A forwarding:
  - fwd_a_sel=2 if MEM.valid & MEM.reg_write & MEM.dst!=0 & MEM.dst==EX.rs.
  - Otherwise fwd_a_sel=1 if the same conditions hold against WB.
  - Otherwise fwd_a_sel=0.
  - MEM has priority over WB.
- Operand B uses the same rule against EX.rt.
- Value 3 is never driven on either select.
- Register 0 is never forwarded and never causes a stall.
- Load-use:
  - stall_id=1 when id_valid & EX.valid & EX.mem_read & EX.dst!=0 & (EX.dst==id_rs | (id_rt_used & EX.dst==id_rt)).
  - The stall lasts exactly one cycle. Next cycle EX holds the bubble, and the load has moved to MEM, where it is not forwardable from the EX/MEM ALU path. One cycle later the load is in WB and the consumer gets fwd_*_sel=1.
- Simultaneous ex_flush and stall_id: EX gets a bubble and stall_id is still asserted. The core's flush takes precedence over its ID hold.
- stall_cnt saturates at all-ones.

## Timing
- On the first cycle after rst is sampled high, all slots are invalid: fwd_a_sel=0, fwd_b_sel=0, stall_id=0, stall_cnt=0.
- A reset asserted mid-operation clears all slots on the next edge. In-flight instructions are forgotten; no stall is carried over.
- fwd_*_sel are combinational from registered slot state. They are valid from the start of the cycle in which the instruction occupies EX, with zero added latency.
- stall_id is combinational from the ID inputs and the EX slot, and is valid in the same cycle as the ID inputs.
- The block has no internal clock enable; the core always advances EX/MEM/WB.

## Configuration
- FWD_PERF_CNT_EN defined:
  - stall_cnt port and counter are present.
  - The counter increments on every cycle with stall_id=1 and clears on rst.
- Not defined:
  - Port and counter are absent.
  - Forwarding and stall behaviour are identical.

## Structure
- A shared package holds:
  - select encodings FWD_RF=2'd0, FWD_WB=2'd1, FWD_MEM=2'd2
  - a stage-slot struct typedef
  - REG_AW
- The operand-mux code uses the same package constants.
- One sub-module, fwd_match: a comparator that produces one 2-bit select from {src, MEM slot, WB slot}. It is instantiated twice, for A and B.

## Test plan
- Reset test: hold rst for 2 cycles with random inputs -> fwd_a_sel=0, fwd_b_sel=0, stall_id=0, stall_cnt=0.
- EX/MEM forward: add $3 then add using $3 as rs in the next cycle -> the consumer's EX cycle shows fwd_a_sel=2.
- WB forward: two producers with one unrelated instruction between, then a consumer with rt=$3 and rt_used=1 -> fwd_b_sel=1.
- Priority: two back-to-back writes to $5, then a reader of $5 -> fwd_a_sel=2, never 1.
- Zero-register guard: write to $0, then read $0 on both operands -> both selects 0.
- Load-use: lw $4, then add reading rs=$4:
  - stall_id=1 for exactly one cycle, then 0.
  - The add reaches EX with fwd_a_sel=1.
  - stall_cnt=1 when FWD_PERF_CNT_EN is defined.
- Flush during stall: the same load-use sequence with ex_flush=1 on the stall cycle -> EX bubble inserted, and no forwarding asserts from the squashed slot.
